// File: rtl/dotp_axil_master.sv
// AXI4-Lite initiator for the dot-product accelerator: turns single-beat host
// commands into AW/W/B or AR/R transactions, one outstanding, with a watchdog.
module dotp_axil_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic aw_hs, w_hs, wr_done, expire;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    cnt_d         = '0;

    aw_hs   = awvalid_q & awready;
    w_hs    = wvalid_q & wready;
    // A channel counts as done if it already handshook or does so this edge.
    wr_done = (~awvalid_q | aw_hs) & (~wvalid_q | w_hs);
    expire  = (TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST));

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (wr_done) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (bvalid) begin
          state_d       = RESP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_resp_d    = bresp;
          rsp_rdata_d   = '0;
        end
      end
      RADDR: begin
        if (arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid) begin
          state_d       = RESP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_resp_d    = rresp;
          rsp_rdata_d   = rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only fires if the wait state did not complete on this edge.
    if (expire && (state_d == state_q) &&
        (state_q == WADDR || state_q == WRESP ||
         state_q == RADDR || state_q == RDATA)) begin
      state_d       = RESP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = '0;
      rsp_rdata_d   = '0;
    end

    if ((state_d == state_q) &&
        (state_q == WADDR || state_q == WRESP ||
         state_q == RADDR || state_q == RDATA)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dotp_axil_master.sv
// Directed bench for dotp_axil_master: the bench plays host and AXI-Lite slave,
// driving and sampling on the falling clock edge.
module tb_dotp_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready, busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dotp_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one command for exactly one cycle; caller is at a falling edge in IDLE.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    step();
    cmd_valid = 1'b0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int unsigned cyc;
    logic        seen;

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, bready}, 32'd0);
    check("rst_rsp", {29'd0, rready, rsp_valid, rsp_timeout}, 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 32'h00, 32'd11, 4'hF);
    check("zw_aw_w_same", {30'd0, awvalid, wvalid}, 32'd3);
    check("zw_wdata", wdata, 32'd11);
    check("zw_wstrb", 32'(wstrb), 32'hF);
    check("zw_cmd_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
    step();
    check("zw_bready", {29'd0, bready, awvalid, wvalid}, 32'd4);
    check("zw_no_early_rsp", 32'(rsp_valid), 32'd0);
    step();
    check("zw_rsp_valid_cyc3", 32'(rsp_valid), 32'd1);
    check("zw_rsp_resp", 32'(rsp_resp), 32'd0);
    check("zw_rsp_rdata", rsp_rdata, 32'd0);
    check("zw_bready_drop", 32'(bready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("zw_back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    bvalid = 1'b0; awready = 1'b0;

    // Staggered write channels: AW accepted after 4 cycles, W immediately
    issue(1'b1, 32'h04, 32'h22, 4'h3);
    check("stg_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stg_wvalid_dropped", 32'(wvalid), 32'd0);
      check("stg_awvalid_held", 32'(awvalid), 32'd1);
      check("stg_awaddr_stable", awaddr, 32'h04);
      check("stg_no_bready", 32'(bready), 32'd0);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    check("stg_bready_after_both", {30'd0, bready, awvalid}, 32'd2);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("stg_rsp", {29'd0, rsp_valid, rsp_resp}, 32'd4);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Read of result register with rvalid delayed 5 cycles
    arready = 1'b1;
    issue(1'b0, 32'h10, 32'd0, 4'h0);
    check("rd_arvalid", 32'(arvalid), 32'd1);
    check("rd_araddr", araddr, 32'h10);
    step();
    arready = 1'b0;
    check("rd_rready", {30'd0, rready, arvalid}, 32'd2);
    for (int i = 0; i < 4; i++) step();
    check("rd_still_waiting", {30'd0, rready, rsp_valid}, 32'd2);
    step();
    rvalid = 1'b1; rdata = 32'hFFFF_FF9E; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = '0;
    check("rd_rsp_valid", {30'd0, rsp_valid, rready}, 32'd2);
    check("rd_rsp_rdata", rsp_rdata, 32'hFFFF_FF9E);
    check("rd_rsp_resp", 32'(rsp_resp), 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // SLVERR write response with host backpressure
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    issue(1'b1, 32'h08, 32'h5, 4'hF);
    check("err_cmd_ready_waddr", 32'(cmd_ready), 32'd0);
    step();
    check("err_cmd_ready_wresp", 32'(cmd_ready), 32'd0);
    step();
    bvalid = 1'b0; bresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("err_rsp_held", {29'd0, rsp_valid, rsp_resp}, 32'd6);
      check("err_cmd_ready_resp", 32'(cmd_ready), 32'd0);
      if (i < 2) step();
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    check("err_idle", {29'd0, cmd_ready, busy, rsp_valid}, 32'd4);
    awready = 1'b0; wready = 1'b0;

    // Watchdog expiry on AR with arready low
    issue(1'b0, 32'h0C, 32'd0, 4'h0);
    cyc = 0;
    while (arvalid && cyc < 20) begin
      cyc++;
      step();
    end
    check("to_arvalid_cycles", cyc, 32'd8);
    check("to_rsp_flags", {30'd0, rsp_valid, rsp_timeout}, 32'd3);
    check("to_rsp_resp", 32'(rsp_resp), 32'd0);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_axi_idle", {30'd0, arvalid, rready}, 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    check("to_flag_cleared", 32'(rsp_timeout), 32'd0);

    // Handshake in the expiry cycle wins over the watchdog
    issue(1'b0, 32'h14, 32'd0, 4'h0);
    for (int i = 0; i < 7; i++) step();
    check("edge_arvalid_last", 32'(arvalid), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("edge_no_timeout", {29'd0, rready, rsp_valid, rsp_timeout}, 32'd4);
    rvalid = 1'b1; rdata = 32'h1234; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = '0;
    check("edge_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd2);
    check("edge_rdata", rsp_rdata, 32'h1234);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Next command after a timeout completes normally
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(1'b1, 32'h18, 32'h77, 4'hF);
    step(); step();
    check("post_to_write", {29'd0, rsp_valid, rsp_timeout, busy}, 32'd5);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset asserted mid-RDATA
    arready = 1'b1;
    issue(1'b0, 32'h10, 32'd0, 4'h0);
    step();
    arready = 1'b0;
    check("mid_rready_before", 32'(rready), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_outputs", {29'd0, rready, rsp_valid, busy}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid || busy || rready) seen = 1'b1;
    end
    check("mid_no_stale_rsp", 32'(seen), 32'd0);
    rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dotp_axil_master.md
Name: dotp_axil_master

Overview:
- AXI4-Lite initiator that drives the dot-product accelerator's AXI-Lite slave.
- Accepts single-beat read/write commands from a host-side sequencer (CPU model or test controller) over a valid/ready command port.
- Issues the matching AW/W/B or AR/R transactions and returns one response per command, with a per-transaction watchdog.
- Sits between the host sequencer and the accelerator slave; exactly one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (fixed at 32; WSTRB is DATA_W/8 bits).
- TIMEOUT, 256, cycles allowed per channel handshake before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP; 2'b00 on timeout.
- rsp_timeout  out  1  transaction aborted by the watchdog.
- awaddr  out  ADDR_W;  awvalid  out  1;  awready  in  1.
- wdata  out  DATA_W;  wstrb  out  DATA_W/8;  wvalid  out  1;  wready  in  1.
- bresp  in  2;  bvalid  in  1;  bready  out  1.
- araddr  out  ADDR_W;  arvalid  out  1;  arready  in  1.
- rdata  in  DATA_W;  rresp  in  2;  rvalid  in  1;  rready  out  1.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst low, asynchronous): FSM enters IDLE. All valids, bready, rready, rsp_valid, rsp_timeout and busy are 0. All address, data and response registers are 0. Leaving reset is synchronous to the first clk edge with rst high.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch address, data and strobes.
  - Write: go to WADDR with awvalid=1 and wvalid=1 in the next cycle.
  - Read: go to RADDR with arvalid=1 in the next cycle.
- WADDR:
  - awvalid and wvalid drop independently on their own handshake (valid & ready at a clk edge).
  - Both handshakes in the same cycle is legal.
  - When both channels are done, go to WRESP with bready=1.
  - Addresses and data hold stable while their valid is high.
- WRESP: on bvalid & bready, capture bresp, set rsp_rdata=0 and go to RESP. bready drops in that cycle.
- RADDR: on arready, drop arvalid and go to RDATA with rready=1.
- RDATA: on rvalid, capture rdata and rresp, drop rready and go to RESP.
- RESP:
  - rsp_valid=1; outputs hold until rsp_ready.
  - On rsp_ready, return to IDLE. cmd_ready rises the following cycle; back-to-back commands are never accepted in the RESP cycle.
- Latency with a zero-wait slave:
  - Write: cmd accept to rsp_valid is 3 cycles.
  - Read: cmd accept to rsp_valid is 3 cycles.
- Watchdog:
  - The counter clears on state entry and increments each cycle in WADDR, WRESP, RADDR and RDATA.
  - At count == TIMEOUT-1 without completion, all AXI valids and readies are forced to 0 and the FSM goes to RESP with rsp_timeout=1, rsp_resp=0 and rsp_rdata=0.
  - A handshake completing in the same cycle as expiry wins: no timeout is flagged.
  - The counter is sized as clog2(TIMEOUT+1).
- Never asserts valid combinationally from ready. No outstanding transaction carries over a reset.
- Reset mid-transaction: all outputs return to reset values immediately, and any pending response is discarded.
- SLVERR/DECERR responses are passed through on rsp_resp; they are not retried.

Test Plan:
- Zero-wait write: cmd write addr 0x00, data 11, strb 0xF.
  - Required: awvalid and wvalid in the same cycle.
  - Required: rsp_valid 3 cycles after accept with rsp_resp=00 and rsp_rdata=0.
- Staggered write channels: awready delayed 4 cycles, wready immediate.
  - Required: wvalid drops after 1 cycle, awvalid holds with awaddr stable, and bready rises only after both handshakes.
- Read of the result register at 0x10 with rvalid delayed 5 cycles, rdata=0xFFFFFF9E (-98).
  - Required: rsp_rdata=0xFFFFFF9E and rsp_resp=00.
- Error and backpressure: slave returns bresp=10, and rsp_ready is held low for 3 cycles.
  - Required: rsp_resp=10 is stable for 3 cycles, then IDLE.
  - Required: cmd_ready=0 throughout.
- Timeout with TIMEOUT=8 and arready tied low.
  - Required: arvalid drops 8 cycles after RADDR entry, rsp_timeout=1, and the next command completes normally.
- Reset mid-RDATA: pull rst low while rready=1.
  - Required: rready, rsp_valid and busy are 0 immediately, with no response emitted after reset release.
